dice_roll_ctrl: RTL
===================

DICE_ROLL_CTRL -- requirements
Module: dice_roll_ctrl

Interface
REQ-001 Parameter SEED, 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-002 Parameter ANIM_FRAMES, 8, number of shuffle frames per roll (1..255).
REQ-003 Parameter FRAME_DIV, 5_000_000, clock cycles per animation frame (>=1).
REQ-004 Port clk  in  1  system clock; single clock domain.
REQ-005 Port reset_n  in  1  asynchronous active-low reset.
REQ-006 Port roll_trigger  in  1  one-cycle roll request from the game FSM.
REQ-007 Port turn_start  in  1  one-cycle pulse that clears all dice for a new turn.
REQ-008 Port hold_sw  in  5  bit i=1 keeps die i unchanged.
REQ-009 Port dice  out  15  settled dice; die i at [3i+2:3i]; values 0 (unset) or 1..6.
REQ-010 Port disp_dice  out  15  display dice; same packing; shows shuffle during animation.
REQ-011 Port busy  out  1  high while a roll is in progress.
REQ-012 Port roll_done  out  1  one-cycle pulse when all dice are settled.

Function
REQ-013 States: IDLE, ANIM, SETTLE, DONE; busy SHALL be 1 in every state except IDLE.
REQ-014 LFSR SHALL be 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advancing every clock in every state.
REQ-015 IDLE + roll_trigger SHALL latch hold_sw into hold_q and go to ANIM (SETTLE if animation disabled).
REQ-016 A die whose dice value is 0 SHALL be rolled regardless of hold_q.
REQ-017 ANIM SHALL last exactly ANIM_FRAMES*FRAME_DIV cycles; on each frame tick the disp_dice field of every non-held die SHALL load a new value.
REQ-018 During ANIM and SETTLE, dice fields of non-held dice SHALL read 0 until assigned; held dice SHALL keep their values.
REQ-019 SETTLE SHALL last exactly 5 cycles; in cycle k (0..4) die k, if not held, SHALL take (lfsr[7:0] mod 6)+1 in both dice and disp_dice.
REQ-020 After SETTLE the FSM SHALL spend one cycle in DONE with roll_done=1, then return to IDLE.
REQ-021 Latency without animation: trigger in cycle T, roll_done high in cycle T+6, busy low from T+7.
REQ-022 roll_trigger while busy SHALL be ignored, with no queuing.
REQ-023 turn_start SHALL have priority over everything else: from any state, dice and disp_dice go to 0, the FSM goes to IDLE and roll_done is not asserted.
REQ-024 turn_start and roll_trigger in the same IDLE cycle: the clear wins and the roll is dropped.
REQ-025 In IDLE, disp_dice SHALL equal dice.
REQ-026 The frame counter SHALL wrap at FRAME_DIV-1 and clear on entry to ANIM.

Reset
REQ-027 During reset: dice=0, disp_dice=0, busy=0, roll_done=0, state=IDLE, lfsr=SEED, hold_q=0, counters=0.
REQ-028 Reset asserted mid-roll SHALL abort immediately with no roll_done.

Configuration
REQ-029 With macro DICE_ROLL_ANIM_EN defined, the ANIM state, frame counter and frame counter SHALL be present.
REQ-030 Without DICE_ROLL_ANIM_EN, IDLE SHALL go directly to SETTLE and disp_dice SHALL equal dice at all times; the parameters SHALL be accepted but unused.

Structure
REQ-031 Shared package yacht_pkg SHALL hold NUM_DICE=5, DIE_W=3, the dice-state enum and the LFSR tap constant.
REQ-032 The LFSR SHALL be a sub-module dice_lfsr (ports clk, reset_n, seed, q[15:0]).

Verification
REQ-033 Reset release -> dice=15'h0, busy=0, and lfsr=16'hACE1 on the first clock.
REQ-034 No animation; turn_start, then roll_trigger at T -> roll_done at T+6; each field in 1..6 and equal to the model LFSR value mod 6 +1.
REQ-035 dice holds 3,5,2,6,1; hold_sw=5'b00101; roll -> die0=1 and die2=2 unchanged; the others are re-rolled.
REQ-036 turn_start in SETTLE cycle 2 -> dice=0 next cycle, busy=0, no roll_done.
REQ-037 Extra roll_trigger pulses at T+2 and T+4 -> exactly one roll_done.
REQ-038 DICE_ROLL_ANIM_EN, ANIM_FRAMES=2, FRAME_DIV=3 -> ANIM lasts 6 cycles, 2 disp_dice updates, and roll_done at T+12.

Source files
------------

// File: rtl/yacht_pkg.sv
// Shared definitions for the yacht dice datapath.
// Holds the die count and width, the roll-controller state encoding, the
// LFSR tap mask and a helper that maps a random byte onto a die face.
package yacht_pkg;

  localparam int unsigned NUM_DICE = 5;
  localparam int unsigned DIE_W    = 3;
  localparam int unsigned DICE_W   = NUM_DICE * DIE_W;
  localparam int unsigned LFSR_W   = 16;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ANIM   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } dice_state_e;

  // Map a random byte onto a die face 1..6
  function automatic logic [DIE_W-1:0] die_from_byte(input logic [7:0] b);
    logic [7:0] r;
    r = b % 8'd6;
    return DIE_W'(r) + DIE_W'(1);
  endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Galois LFSR used as the dice random source.
// Ports: clk, reset_n (async, active low), seed (reset value, nonzero),
//        q (current LFSR state, advances every clock).
module dice_lfsr
  import yacht_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  // Shift right; when the bit shifted out is 1 fold the taps back in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= seed;
    end else if (q[0]) begin
      q <= (q >> 1) ^ LFSR_TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll controller for a five-dice yacht game.
// A roll request latches the hold switches, optionally shuffles the display
// for an animation period, then settles one die per cycle from the LFSR and
// pulses roll_done. turn_start clears all dice and aborts any roll.
// Optional feature macro: DICE_ROLL_ANIM_EN enables the ANIM state and the
// frame counters; without it ANIM_FRAMES/FRAME_DIV are accepted but unused
// and disp_dice mirrors dice.
// Ports: clk, reset_n (async, active low), roll_trigger, turn_start,
//        hold_sw[4:0], dice[14:0], disp_dice[14:0], busy, roll_done.
module dice_roll_ctrl
  import yacht_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned ANIM_FRAMES = 8,
  parameter int unsigned FRAME_DIV   = 5_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                roll_trigger,
  input  logic                turn_start,
  input  logic [NUM_DICE-1:0] hold_sw,
  output logic [DICE_W-1:0]   dice,
  output logic [DICE_W-1:0]   disp_dice,
  output logic                busy,
  output logic                roll_done
);

  dice_state_e         state_q, state_d;
  logic [LFSR_W-1:0]   lfsr;
  logic [NUM_DICE-1:0] hold_q, hold_eff_c;
  logic [DICE_W-1:0]   dice_q, hold_mask_c;
  logic [2:0]          settle_idx_q;
  logic [DIE_W-1:0]    settle_val_c;
  logic                roll_start_c, anim_done_c;
  logic                busy_q, roll_done_q;

  dice_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (SEED),
    .q       (lfsr)
  );

  // A die still at 0 cannot be held; it must be rolled
  always_comb begin
    hold_eff_c  = '0;
    hold_mask_c = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      hold_eff_c[i] = hold_sw[i] && (dice_q[i*DIE_W +: DIE_W] != '0);
      hold_mask_c[i*DIE_W +: DIE_W] = {DIE_W{hold_eff_c[i]}};
    end
  end

  assign roll_start_c = (state_q == ST_IDLE) && roll_trigger && !turn_start;
  assign settle_val_c = die_from_byte(lfsr[7:0]);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; turn_start overrides every transition
  always_comb begin
    state_d = state_q;
    if (turn_start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (roll_trigger) begin
`ifdef DICE_ROLL_ANIM_EN
            state_d = ST_ANIM;
`else
            state_d = ST_SETTLE;
`endif
          end
        end
        ST_ANIM: begin
          if (anim_done_c) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_idx_q == 3'(NUM_DICE - 1)) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Settled dice, latched holds and settle index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dice_q       <= '0;
      hold_q       <= '0;
      settle_idx_q <= '0;
    end else if (turn_start) begin
      dice_q       <= '0;
      hold_q       <= '0;
      settle_idx_q <= '0;
    end else if (roll_start_c) begin
      hold_q       <= hold_eff_c;
      dice_q       <= dice_q & hold_mask_c;
      settle_idx_q <= '0;
    end else if (state_q == ST_SETTLE) begin
      for (int i = 0; i < NUM_DICE; i++) begin
        if ((settle_idx_q == 3'(i)) && !hold_q[i]) begin
          dice_q[i*DIE_W +: DIE_W] <= settle_val_c;
        end
      end
      settle_idx_q <= settle_idx_q + 3'd1;
    end
  end

  // Status flags follow the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      roll_done_q <= 1'b0;
    end else begin
      busy_q      <= (state_d != ST_IDLE);
      roll_done_q <= (state_d == ST_DONE);
    end
  end

`ifdef DICE_ROLL_ANIM_EN
  logic [31:0]       frame_cnt_q;
  logic [7:0]        frame_idx_q;
  logic              frame_tick_c;
  logic [DICE_W-1:0] disp_q;

  assign frame_tick_c = (state_q == ST_ANIM) && (frame_cnt_q == 32'(FRAME_DIV - 1));
  assign anim_done_c  = frame_tick_c && (frame_idx_q == 8'(ANIM_FRAMES - 1));

  // Frame divider and frame index, cleared when a roll starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      frame_idx_q <= '0;
    end else if (turn_start || roll_start_c) begin
      frame_cnt_q <= '0;
      frame_idx_q <= '0;
    end else if (state_q == ST_ANIM) begin
      if (frame_tick_c) begin
        frame_cnt_q <= '0;
        frame_idx_q <= frame_idx_q + 8'd1;
      end else begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
    end
  end

  // Display copy: shuffles non-held dice per frame, then tracks settling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q <= '0;
    end else if (turn_start) begin
      disp_q <= '0;
    end else if (roll_start_c) begin
      disp_q <= dice_q & hold_mask_c;
    end else if (frame_tick_c) begin
      for (int i = 0; i < NUM_DICE; i++) begin
        if (!hold_q[i]) disp_q[i*DIE_W +: DIE_W] <= die_from_byte(lfsr[2*i +: 8]);
      end
    end else if (state_q == ST_SETTLE) begin
      for (int i = 0; i < NUM_DICE; i++) begin
        if ((settle_idx_q == 3'(i)) && !hold_q[i]) begin
          disp_q[i*DIE_W +: DIE_W] <= settle_val_c;
        end
      end
    end
  end

  assign disp_dice = disp_q;
`else
  logic unused_anim_cfg;

  assign anim_done_c     = 1'b0;
  assign disp_dice       = dice_q;
  assign unused_anim_cfg = ^{32'(ANIM_FRAMES), 32'(FRAME_DIV), lfsr[15:8]};
`endif

  assign dice      = dice_q;
  assign busy      = busy_q;
  assign roll_done = roll_done_q;

endmodule
